// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared constants, FSM encoding and fixed-point helpers for cordic_sched
// Purpose: TWO_PI constant generator, scheduler state encoding, real->fixed-point helpers.
// Ports: none (package).
package cordic_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam real PI_R = 3.14159265358979323846;

  // round(2*pi * 2^fpshift), masked to width+1 bits so it always fits the
  // normaliser's extended arithmetic. Real-to-integral casts round to nearest.
  function automatic logic [63:0] two_pi(input int width, input int fpshift);
    logic [63:0] v;
    logic [63:0] mask;
    v    = 64'(longint'(2.0 * PI_R * (2.0 ** fpshift)));
    mask = (64'd1 << (width + 1)) - 64'd1;
    return v & mask;
  endfunction

  function automatic longint fp(input real x, input int fpshift);
    return longint'(x * (2.0 ** fpshift));
  endfunction

  function automatic real deg2radians(input real deg);
    return deg * PI_R / 180.0;
  endfunction

endpackage

// File: rtl/cordic_sched_if.sv
// rtl/cordic_sched_if.sv - requester, core and result signals of the CORDIC scheduler
// Purpose: bundles both requester handshakes, the core angle/sine/cosine link and the result handshake.
// Ports: slave = scheduler side, master = requesters/core/consumer side.
interface cordic_sched_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req1_valid;
  logic             req0_ready;
  logic             req1_ready;
  logic [WIDTH-1:0] req0_angle;
  logic [WIDTH-1:0] req1_angle;
  logic [WIDTH-1:0] core_angle;
  logic [WIDTH-1:0] core_sine;
  logic [WIDTH-1:0] core_cosine;
  logic             res_valid;
  logic             res_ready;
  logic             res_id;
  logic [WIDTH-1:0] res_sine;
  logic [WIDTH-1:0] res_cosine;
  logic             busy;

  modport slave (
    input  req0_valid, req1_valid, req0_angle, req1_angle,
    input  core_sine, core_cosine, res_ready,
    output req0_ready, req1_ready, core_angle,
    output res_valid, res_id, res_sine, res_cosine, busy
  );

  modport master (
    output req0_valid, req1_valid, req0_angle, req1_angle,
    output core_sine, core_cosine, res_ready,
    input  req0_ready, req1_ready, core_angle,
    input  res_valid, res_id, res_sine, res_cosine, busy
  );
endinterface

// File: rtl/cordic_sched_rr_arb2.sv
// rtl/cordic_sched_rr_arb2.sv - two-way round-robin grant, combinational
// Purpose: picks the requester to serve; on a tie the one not granted last time wins.
// Ports: valid0/valid1 requests, last_grant previous winner, grant winner (0/1).
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant
);
  // With no request the grant value is irrelevant; it defaults to valid1 (0).
  assign grant = (valid0 && valid1) ? !last_grant : valid1;
endmodule

// File: rtl/cordic_sched.sv
// rtl/cordic_sched.sv - shares one CORDIC core between two angle requesters
// Purpose: round-robin arbitration, angle normalisation into [0, 2pi), latency hold, result register.
// Ports: clk, rst_n (async active-low), bus (cordic_sched_if.slave: requests, core link, result, busy).
module cordic_sched
  import cordic_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int FPSHIFT = 28,
  parameter int LATENCY = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  cordic_sched_if.slave     bus
);

  localparam logic signed [WIDTH:0] TWO_PI_X = (WIDTH+1)'(two_pi(WIDTH, FPSHIFT));
  localparam logic [WIDTH-1:0]      TWO_PI_W = TWO_PI_X[WIDTH-1:0];
  localparam logic [7:0]            CNT_LOAD = 8'(LATENCY - 1);

  logic [1:0]              state;
  logic [7:0]              cnt;
  logic                    last_grant;
  logic                    grant;
  logic                    xfer;
  logic [WIDTH-1:0]        sel_angle;
  logic [WIDTH-1:0]        norm_angle;
  logic signed [WIDTH:0]   ang_x;

  rr_arb2 u_arb (
    .valid0     (bus.req0_valid),
    .valid1     (bus.req1_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign bus.req0_ready = (state == ST_IDLE) && !grant && bus.req0_valid;
  assign bus.req1_ready = (state == ST_IDLE) &&  grant && bus.req1_valid;
  assign xfer           = bus.req0_ready || bus.req1_ready;
  assign bus.busy       = (state != ST_IDLE);

  assign sel_angle = grant ? bus.req1_angle : bus.req0_angle;
  assign ang_x     = $signed({sel_angle[WIDTH-1], sel_angle});

  // Single correction step. The range test needs the extra bit; the sum
  // itself is taken modulo 2^WIDTH, which equals the wide result truncated.
  always_comb begin
    norm_angle = sel_angle;
    if (ang_x[WIDTH]) begin
      norm_angle = sel_angle + TWO_PI_W;
    end else if (ang_x >= TWO_PI_X) begin
      norm_angle = sel_angle - TWO_PI_W;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      last_grant     <= 1'b1;
      bus.core_angle <= '0;
      bus.res_valid  <= 1'b0;
      bus.res_id     <= 1'b0;
      bus.res_sine   <= '0;
      bus.res_cosine <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (xfer) begin
            bus.core_angle <= norm_angle;
            bus.res_id     <= grant;
            last_grant     <= grant;
            cnt            <= CNT_LOAD;
            state          <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // cnt counts the settling edges still owed to the core
          if (cnt == 8'd0) begin
            bus.res_sine   <= bus.core_sine;
            bus.res_cosine <= bus.core_cosine;
            bus.res_valid  <= 1'b1;
            state          <= ST_DONE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_DONE: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_sched.sv
// tb/tb_cordic_sched.sv - self-checking bench for cordic_sched (table vectors, scoreboard, corner sequences)
module tb_cordic_sched;

  localparam int W   = 32;
  localparam int LAT = 32;

  typedef struct {
    logic        sel;
    logic [31:0] angle;
    logic [31:0] exp_core;
  } vec_t;

  typedef struct {
    logic        id;
    logic [31:0] sine;
    logic [31:0] cosine;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  exp_t sb[$];
  vec_t vecs[7];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cordic_sched_if #(.WIDTH(W)) bus ();
  cordic_sched_if #(.WIDTH(W)) bus1 ();

  // Core stub: sine echoes the angle, cosine is angle+1.
  assign bus.core_sine    = bus.core_angle;
  assign bus.core_cosine  = bus.core_angle + 32'd1;
  assign bus1.core_sine   = bus1.core_angle;
  assign bus1.core_cosine = bus1.core_angle + 32'd1;

  cordic_sched #(.WIDTH(W), .FPSHIFT(28), .LATENCY(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  cordic_sched #(.WIDTH(W), .FPSHIFT(28), .LATENCY(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  function automatic logic [31:0] norm_model(input logic [31:0] a);
    longint v;
    v = longint'($signed(a));
    if (v < 0) v = v + 64'sd1686629713;
    else if (v >= 64'sd1686629713) v = v - 64'sd1686629713;
    return v[31:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: push on transfer, pop and compare on result acceptance.
  exp_t e;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.req0_valid && bus.req0_ready) begin
        e.id = 1'b0; e.sine = norm_model(bus.req0_angle); e.cosine = e.sine + 32'd1;
        sb.push_back(e);
      end
      if (bus.req1_valid && bus.req1_ready) begin
        e.id = 1'b1; e.sine = norm_model(bus.req1_angle); e.cosine = e.sine + 32'd1;
        sb.push_back(e);
      end
      if (bus.res_valid && bus.res_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("sb_id", 32'(bus.res_id), 32'(e.id));
          chk("sb_sine", bus.res_sine, e.sine);
          chk("sb_cosine", bus.res_cosine, e.cosine);
        end
      end
    end
  end

  task automatic run_vec(input logic sel, input logic [31:0] ang, input logic [31:0] exp_ca);
    int   t;
    logic seen;
    if (sel) begin bus.req1_valid = 1'b1; bus.req1_angle = ang; end
    else     begin bus.req0_valid = 1'b1; bus.req0_angle = ang; end
    t = 0;
    @(negedge clk);
    seen = sel ? bus.req1_ready : bus.req0_ready;
    while (!seen && t < 100) begin
      @(negedge clk);
      t++;
      seen = sel ? bus.req1_ready : bus.req0_ready;
    end
    chk("xfer_seen", 32'(seen), 32'd1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk("core_angle", bus.core_angle, exp_ca);
    chk("busy_wait", 32'(bus.busy), 32'd1);
    t = 0;
    while (!bus.res_valid && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    chk("latency", t, LAT);
    chk("res_id", 32'(bus.res_id), 32'(sel));
    chk("res_sine", bus.res_sine, exp_ca);
    @(posedge clk); #1;
    chk("idle_after_accept", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int last_c;
    logic [31:0] a;

    vecs[0] = '{1'b0, 32'd140552476,  32'd140552476};
    vecs[1] = '{1'b1, 32'hF000_0000,  32'd1418194257};
    vecs[2] = '{1'b0, 32'h7000_0000,  32'd192418479};
    vecs[3] = '{1'b1, 32'd0,          32'd0};
    vecs[4] = '{1'b0, 32'd1686629713, 32'd0};
    vecs[5] = '{1'b1, 32'd1686629712, 32'd1686629712};
    vecs[6] = '{1'b0, 32'hFFFF_FFFF,  32'd1686629712};

    rst_n = 1'b0;
    bus.req0_valid = 1'b0;  bus.req1_valid = 1'b0;
    bus.req0_angle = '0;    bus.req1_angle = '0;
    bus.res_ready  = 1'b1;
    bus1.req0_valid = 1'b0; bus1.req1_valid = 1'b0;
    bus1.req0_angle = '0;   bus1.req1_angle = '0;
    bus1.res_ready  = 1'b1;
    last_c = 0;

    repeat (3) @(posedge clk); #1;
    chk("rst0_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst0_res_id", 32'(bus.res_id), 32'd0);
    chk("rst0_res_sine", bus.res_sine, 32'd0);
    chk("rst0_res_cosine", bus.res_cosine, 32'd0);
    chk("rst0_core_angle", bus.core_angle, 32'd0);
    chk("rst0_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i].sel, vecs[i].angle, vecs[i].exp_core);

    // Backpressure: hold result with both requesters waiting.
    bus.res_ready  = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_angle = 32'd300000000;
    t = 0;
    @(negedge clk);
    while (!bus.req0_ready && t < 100) begin @(negedge clk); t++; end
    chk("bp_seen", 32'(t < 100), 32'd1);
    @(posedge clk); #1;
    bus.req1_valid = 1'b1;
    bus.req1_angle = 32'd5;
    t = 0;
    while (!bus.res_valid && t < 300) begin @(posedge clk); #1; t++; end
    chk("bp_latency", t, LAT);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(bus.res_valid), 32'd1);
      chk("bp_id", 32'(bus.res_id), 32'd0);
      chk("bp_sine", bus.res_sine, 32'd300000000);
      chk("bp_cosine", bus.res_cosine, 32'd300000001);
      chk("bp_ready0", 32'(bus.req0_ready), 32'd0);
      chk("bp_ready1", 32'(bus.req1_ready), 32'd0);
      chk("bp_busy", 32'(bus.busy), 32'd1);
    end
    bus.res_ready  = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_release_busy", 32'(bus.busy), 32'd0);
    chk("bp_release_valid", 32'(bus.res_valid), 32'd0);

    // Contention from reset: grants alternate 0,1,0,1 every LAT+2 cycles.
    rst_n = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_angle = 32'd100;
    bus.req1_valid = 1'b1; bus.req1_angle = 32'd200;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      t = 0;
      @(negedge clk);
      while (!(bus.req0_ready || bus.req1_ready) && t < 200) begin @(negedge clk); t++; end
      chk("cont_seen", 32'(t < 200), 32'd1);
      chk("cont_grant", 32'(bus.req1_ready), k % 2);
      chk("cont_one_hot", 32'(bus.req0_ready && bus.req1_ready), 32'd0);
      if (k > 0) chk("cont_interval", cyc - last_c, LAT + 2);
      last_c = cyc;
      @(posedge clk);
    end
    #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    t = 0;
    while (bus.busy && t < 100) begin @(posedge clk); #1; t++; end
    chk("cont_drain", 32'(bus.busy), 32'd0);

    // Reset mid-WAIT abandons the transaction asynchronously.
    bus.req1_valid = 1'b1;
    bus.req1_angle = 32'd555;
    t = 0;
    @(negedge clk);
    while (!bus.req1_ready && t < 100) begin @(negedge clk); t++; end
    chk("mw_seen", 32'(t < 100), 32'd1);
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    repeat (5) @(posedge clk); #1;
    chk("mw_busy", 32'(bus.busy), 32'd1);
    chk("mw_core_angle", bus.core_angle, 32'd555);
    rst_n = 1'b0;
    #1;
    chk("rst_core_angle", bus.core_angle, 32'd0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_id", 32'(bus.res_id), 32'd0);
    chk("rst_res_sine", bus.res_sine, 32'd0);
    chk("rst_res_cosine", bus.res_cosine, 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ready0", 32'(bus.req0_ready), 32'd0);
    chk("rst_ready1", 32'(bus.req1_ready), 32'd0);
    sb.delete();
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    run_vec(1'b1, 32'd777, 32'd777);

    // LATENCY=1 instance: capture one edge after transfer, issue every 3 cycles.
    bus1.req0_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a = 1000 + 7 * k;
      bus1.req0_angle = a;
      t = 0;
      @(negedge clk);
      while (!bus1.req0_ready && t < 20) begin @(negedge clk); t++; end
      chk("l1_seen", 32'(t < 20), 32'd1);
      if (k > 0) chk("l1_interval", cyc - last_c, 3);
      last_c = cyc;
      @(posedge clk); #1;
      chk("l1_core_angle", bus1.core_angle, a);
      chk("l1_not_yet", 32'(bus1.res_valid), 32'd0);
      @(posedge clk); #1;
      chk("l1_valid", 32'(bus1.res_valid), 32'd1);
      chk("l1_sine", bus1.res_sine, a);
    end
    bus1.req0_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("l1_idle", 32'(bus1.busy), 32'd0);

    chk("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
